// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
//   Shared definitions for the block instruction word: opcode constants,
//   branch classification, field bit positions for both formats and the
//   encoder state type. The decoder imports the same package so the word
//   layout can only change in one place.
package instr_encoder_pkg;

  // Opcode constants
  localparam logic [4:0] BLOCK_INSTR_NOP         = 5'h00;
  localparam logic [4:0] BLOCK_INSTR_ADD         = 5'h01;
  localparam logic [4:0] BLOCK_INSTR_SUB         = 5'h02;
  localparam logic [4:0] BLOCK_INSTR_MUL         = 5'h03;
  localparam logic [4:0] BLOCK_INSTR_MADD        = 5'h04;
  localparam logic [4:0] BLOCK_INSTR_SHL         = 5'h05;
  localparam logic [4:0] BLOCK_INSTR_SHR         = 5'h06;
  localparam logic [4:0] BLOCK_INSTR_MIN         = 5'h07;
  localparam logic [4:0] BLOCK_INSTR_MAX         = 5'h08;
  localparam logic [4:0] BLOCK_INSTR_ABS         = 5'h09;
  localparam logic [4:0] BLOCK_INSTR_DELAY_READ  = 5'h10;
  localparam logic [4:0] BLOCK_INSTR_DELAY_WRITE = 5'h11;
  localparam logic [4:0] BLOCK_INSTR_LUT_READ    = 5'h12;
  localparam logic [4:0] BLOCK_INSTR_MEM_READ    = 5'h14;
  localparam logic [4:0] BLOCK_INSTR_MEM_WRITE   = 5'h15;

  // Common field positions
  localparam int FLD_OP_LSB    = 0;
  localparam int FLD_FMT_BIT   = 5;
  localparam int FLD_SRC_A_LSB = 6;
  localparam int FLD_SRC_B_LSB = 11;

  // Format 0 (arithmetic) field positions
  localparam int F0_SRC_C_LSB     = 16;
  localparam int F0_DEST_LSB      = 21;
  localparam int F0_SHIFT_LSB     = 25;
  localparam int F0_SAT_DIS_BIT   = 30;
  localparam int F0_SHIFT_DIS_BIT = 31;

  // Format 1 (resource) field positions
  localparam int F1_DEST_LSB     = 16;
  localparam int F1_RES_ADDR_LSB = 20;

  typedef enum logic [1:0] {
    BRANCH_ALU,
    BRANCH_DELAY,
    BRANCH_LUT,
    BRANCH_MEM
  } instr_branch_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_DONE
  } enc_state_t;

  // Anything not in a resource branch is treated as arithmetic.
  function automatic instr_branch_t op_branch(input logic [4:0] op);
    instr_branch_t br;
    case (op)
      BLOCK_INSTR_DELAY_READ,
      BLOCK_INSTR_DELAY_WRITE: br = BRANCH_DELAY;
      BLOCK_INSTR_LUT_READ:    br = BRANCH_LUT;
      BLOCK_INSTR_MEM_READ,
      BLOCK_INSTR_MEM_WRITE:   br = BRANCH_MEM;
      default:                 br = BRANCH_ALU;
    endcase
    return br;
  endfunction

  // Format bit: 1 for resource-branch ops, 0 otherwise.
  function automatic logic op_format(input logic [4:0] op);
    return op_branch(op) != BRANCH_ALU;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack
//   Combinational descriptor-to-word packer. Selects the format from the
//   opcode, places every field at its package-defined position and flags
//   format-1 descriptors whose unused fields are not clean.
//   Ports:
//     op, src_*, src_*_reg, dest, shift, sat_dis, shift_dis, res_addr : descriptor fields
//     word  : packed 32-bit instruction
//     legal : descriptor may be written
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  src_c,
  input  logic        src_a_reg,
  input  logic        src_b_reg,
  input  logic        src_c_reg,
  input  logic [3:0]  dest,
  input  logic [4:0]  shift,
  input  logic        sat_dis,
  input  logic        shift_dis,
  input  logic [11:0] res_addr,
  output logic [31:0] word,
  output logic        legal
);

  logic fmt;

  // Format 1 has no room for src_c, shift or sat_dis, and the shift-disable
  // bit is carried implicitly by res_addr[11], so those must agree.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    fmt   = op_format(op);
    word[FLD_OP_LSB +: 5]    = op;
    word[FLD_FMT_BIT]        = fmt;
    word[FLD_SRC_A_LSB +: 5] = {src_a_reg, src_a};
    word[FLD_SRC_B_LSB +: 5] = {src_b_reg, src_b};
    if (fmt) begin
      word[F1_DEST_LSB +: 4]      = dest;
      word[F1_RES_ADDR_LSB +: 12] = res_addr;
      legal = (src_c == 4'd0) && !src_c_reg && (shift == 5'd0) && !sat_dis &&
              (shift_dis == res_addr[11]);
    end else begin
      word[F0_SRC_C_LSB +: 5]   = {src_c_reg, src_c};
      word[F0_DEST_LSB +: 4]    = dest;
      word[F0_SHIFT_LSB +: 5]   = shift;
      word[F0_SAT_DIS_BIT]      = sat_dis;
      word[F0_SHIFT_DIS_BIT]    = shift_dis;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//   Owns the program-load sequence: accepts descriptors while loading, packs
//   them into block instruction words, writes them to consecutive program RAM
//   addresses through a one-word output register, then pads the rest of the
//   memory with PAD_WORD and pulses done.
//   Ports:
//     clk, reset               : clock, synchronous active-high reset
//     load_start, load_end     : sequence control pulses
//     in_valid / in_ready      : descriptor handshake, in_* descriptor fields
//     prog_wr_en/addr/data     : program RAM write port (registered)
//     busy, done               : sequence status
//     prog_len                 : count of real instructions written
//     field_err, overflow      : sticky error flags
//     err_index                : accept index of the first bad descriptor
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          N_INSTRS = 256,
  parameter int          ADDR_W   = $clog2(N_INSTRS),
  parameter logic [31:0] PAD_WORD = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [3:0]        in_src_a,
  input  logic [3:0]        in_src_b,
  input  logic [3:0]        in_src_c,
  input  logic              in_src_a_reg,
  input  logic              in_src_b_reg,
  input  logic              in_src_c_reg,
  input  logic [3:0]        in_dest,
  input  logic [4:0]        in_shift,
  input  logic              in_sat_dis,
  input  logic              in_shift_dis,
  input  logic [11:0]       in_res_addr,
  output logic              prog_wr_en,
  output logic [ADDR_W-1:0] prog_wr_addr,
  output logic [31:0]       prog_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              field_err,
  output logic              overflow,
  output logic [ADDR_W:0]   err_index
);

  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(N_INSTRS);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  enc_state_t      state, state_next;
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] acc_cnt;
  logic [31:0]     packed_word;
  logic            packed_legal;
  logic            accept;
  logic            is_full;
  logic            real_wr;
  logic            has_err;

  instr_pack u_pack (
    .op        (in_op),
    .src_a     (in_src_a),
    .src_b     (in_src_b),
    .src_c     (in_src_c),
    .src_a_reg (in_src_a_reg),
    .src_b_reg (in_src_b_reg),
    .src_c_reg (in_src_c_reg),
    .dest      (in_dest),
    .shift     (in_shift),
    .sat_dis   (in_sat_dis),
    .shift_dis (in_shift_dis),
    .res_addr  (in_res_addr),
    .word      (packed_word),
    .legal     (packed_legal)
  );

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign accept   = in_valid && in_ready;
  assign is_full  = (wr_ptr == PTR_FULL);
  assign real_wr  = accept && !is_full && packed_legal;
  assign has_err  = field_err || overflow;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. load_start restarts from any state and outranks
  // load_end; PAD leaves only once the pointer has reached the end.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (load_start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (load_start)    state_next = ST_LOAD;
        else if (load_end) state_next = ST_PAD;
      end
      ST_PAD: begin
        if (load_start)   state_next = ST_LOAD;
        else if (is_full) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (load_start) state_next = ST_LOAD;
        else            state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: pointers, the one-word output register and the error flags.
  // When load_end arrives without a real write in the same cycle, the first
  // pad word goes out on that edge so padding follows the stream gap-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      acc_cnt      <= '0;
      prog_len     <= '0;
      field_err    <= 1'b0;
      overflow     <= 1'b0;
      err_index    <= '0;
      prog_wr_en   <= 1'b0;
      prog_wr_addr <= '0;
      prog_wr_data <= '0;
    end else begin
      prog_wr_en <= 1'b0;
      if (load_start) begin
        wr_ptr    <= '0;
        acc_cnt   <= '0;
        prog_len  <= '0;
        field_err <= 1'b0;
        overflow  <= 1'b0;
        err_index <= '0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (accept) begin
              if (acc_cnt != '1) acc_cnt <= acc_cnt + PTR_ONE;
              if (is_full) begin
                overflow <= 1'b1;
                if (!has_err) err_index <= acc_cnt;
              end else if (!packed_legal) begin
                field_err <= 1'b1;
                if (!has_err) err_index <= acc_cnt;
              end
            end
            if (real_wr) begin
              prog_wr_en   <= 1'b1;
              prog_wr_addr <= wr_ptr[ADDR_W-1:0];
              prog_wr_data <= packed_word;
              wr_ptr       <= wr_ptr + PTR_ONE;
            end else if (load_end && !is_full) begin
              prog_wr_en   <= 1'b1;
              prog_wr_addr <= wr_ptr[ADDR_W-1:0];
              prog_wr_data <= PAD_WORD;
              wr_ptr       <= wr_ptr + PTR_ONE;
            end
            if (load_end) prog_len <= real_wr ? wr_ptr + PTR_ONE : wr_ptr;
          end
          ST_PAD: begin
            if (!is_full) begin
              prog_wr_en   <= 1'b1;
              prog_wr_addr <= wr_ptr[ADDR_W-1:0];
              prog_wr_data <= PAD_WORD;
              wr_ptr       <= wr_ptr + PTR_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed bench for instr_encoder with an 8-word program memory. A
//   behavioural model predicts every RAM write (cycle, address, data) and the
//   done pulse; a negedge compare process checks them each cycle, and
//   directed checks cover flags, lengths and reset behaviour.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int          N   = 8;
  localparam int          AW  = 3;
  localparam logic [31:0] PAD = 32'hA5A5_0F0F;

  logic          clk = 1'b0;
  logic          reset, load_start, load_end, in_valid, in_ready;
  logic [4:0]    in_op, in_shift;
  logic [3:0]    in_src_a, in_src_b, in_src_c, in_dest;
  logic          in_src_a_reg, in_src_b_reg, in_src_c_reg;
  logic          in_sat_dis, in_shift_dis;
  logic [11:0]   in_res_addr;
  logic          prog_wr_en, busy, done, field_err, overflow;
  logic [AW-1:0] prog_wr_addr;
  logic [31:0]   prog_wr_data;
  logic [AW:0]   prog_len, err_index;

  always #5 clk = ~clk;

  instr_encoder #(.N_INSTRS(N), .ADDR_W(AW), .PAD_WORD(PAD)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_end(load_end),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src_a(in_src_a), .in_src_b(in_src_b), .in_src_c(in_src_c),
    .in_src_a_reg(in_src_a_reg), .in_src_b_reg(in_src_b_reg), .in_src_c_reg(in_src_c_reg),
    .in_dest(in_dest), .in_shift(in_shift), .in_sat_dis(in_sat_dis),
    .in_shift_dis(in_shift_dis), .in_res_addr(in_res_addr),
    .prog_wr_en(prog_wr_en), .prog_wr_addr(prog_wr_addr), .prog_wr_data(prog_wr_data),
    .busy(busy), .done(done), .prog_len(prog_len), .field_err(field_err),
    .overflow(overflow), .err_index(err_index)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  src_a;
    logic        src_a_reg;
    logic [3:0]  src_b;
    logic        src_b_reg;
    logic [3:0]  src_c;
    logic        src_c_reg;
    logic [3:0]  dest;
    logic [4:0]  shift;
    logic        sat_dis;
    logic        shift_dis;
    logic [11:0] res_addr;
  } desc_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t exp_q[$];
  int  cyc          = 0;
  int  tests_run    = 0;
  int  tests_failed = 0;
  bit  chk_en       = 1'b0;
  int  exp_done_cyc = -1;

  int  m_ptr, m_acc, m_eidx, m_len;
  bit  m_ferr, m_ovf, m_loading;

  always @(posedge clk) cyc <= cyc + 1;

  // Word layout straight from the field table, with its own list of
  // resource opcodes.
  function automatic void model_word(input desc_t d, output logic [31:0] w, output bit ok);
    bit res;
    res = d.op inside {BLOCK_INSTR_DELAY_READ, BLOCK_INSTR_DELAY_WRITE, BLOCK_INSTR_LUT_READ,
                       BLOCK_INSTR_MEM_READ, BLOCK_INSTR_MEM_WRITE};
    w = 32'(d.op) + 32'(res) * 32'h20 + 32'({d.src_a_reg, d.src_a}) * 32'h40
      + 32'({d.src_b_reg, d.src_b}) * 32'h800;
    if (res) begin
      w  = w + 32'(d.dest) * 32'h1_0000 + 32'(d.res_addr) * 32'h10_0000;
      ok = (d.src_c == 4'd0) && !d.src_c_reg && (d.shift == 5'd0) && !d.sat_dis &&
           (d.shift_dis == (d.res_addr >= 12'h800));
    end else begin
      w  = w + 32'({d.src_c_reg, d.src_c}) * 32'h1_0000 + 32'(d.dest) * 32'h20_0000
         + 32'(d.shift) * 32'h200_0000 + 32'(d.sat_dis) * 32'h4000_0000
         + 32'(d.shift_dis) * 32'h8000_0000;
      ok = 1'b1;
    end
  endfunction

  function automatic desc_t mk_alu(input logic [4:0] op, input int a, input int b, input int c,
                                   input int dst, input int sh);
    desc_t d;
    d = '0;
    d.op = op; d.src_a = 4'(a); d.src_b = 4'(b); d.src_c = 4'(c);
    d.dest = 4'(dst); d.shift = 5'(sh);
    return d;
  endfunction

  function automatic desc_t mk_res(input logic [4:0] op, input int dst, input logic [11:0] ra);
    desc_t d;
    d = '0;
    d.op = op; d.dest = 4'(dst); d.res_addr = ra; d.shift_dis = ra[11];
    return d;
  endfunction

  task automatic push_write(input int c, input int a, input logic [31:0] w);
    wr_t e;
    e.cyc = c; e.addr = AW'(a); e.data = w;
    exp_q.push_back(e);
  endtask

  // Drop predicted writes that an abort prevents from ever appearing.
  task automatic abort_future();
    while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus; the model advances by what the next edge does.
  task automatic applyStimulus(input bit ls, input bit le, input bit v, input desc_t d);
    logic [31:0] w;
    bit          ok;
    bit          wrote;
    int          next_c;
    @(posedge clk); #1;
    load_start = ls; load_end = le; in_valid = v;
    in_op = d.op; in_src_a = d.src_a; in_src_b = d.src_b; in_src_c = d.src_c;
    in_src_a_reg = d.src_a_reg; in_src_b_reg = d.src_b_reg; in_src_c_reg = d.src_c_reg;
    in_dest = d.dest; in_shift = d.shift; in_sat_dis = d.sat_dis;
    in_shift_dis = d.shift_dis; in_res_addr = d.res_addr;
    wrote = 1'b0;
    if (ls) begin
      abort_future();
      m_ptr = 0; m_acc = 0; m_eidx = 0; m_len = 0;
      m_ferr = 1'b0; m_ovf = 1'b0; m_loading = 1'b1;
      exp_done_cyc = -1;
    end else if (m_loading) begin
      if (v) begin
        model_word(d, w, ok);
        if (m_ptr == N) begin
          if (!(m_ferr || m_ovf)) m_eidx = m_acc;
          m_ovf = 1'b1;
        end else if (!ok) begin
          if (!(m_ferr || m_ovf)) m_eidx = m_acc;
          m_ferr = 1'b1;
        end else begin
          push_write(cyc + 1, m_ptr, w);
          m_ptr++;
          wrote = 1'b1;
        end
        m_acc++;
      end
      if (le) begin
        m_len     = m_ptr;
        m_loading = 1'b0;
        next_c    = wrote ? cyc + 2 : cyc + 1;
        for (int a = m_ptr; a < N; a++) begin
          push_write(next_c, a, PAD);
          next_c++;
        end
        exp_done_cyc = (next_c > cyc + 2) ? next_c : cyc + 2;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic applyReset();
    @(posedge clk); #1;
    reset = 1'b1; load_start = 1'b0; load_end = 1'b0; in_valid = 1'b0;
    abort_future();
    exp_done_cyc = -1;
    m_loading = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_end(input string tag, input int len, input bit ferr, input bit ovf, input int eidx);
    checkOutput({tag, "_prog_len"}, 32'(prog_len), 32'(len));
    checkOutput({tag, "_model_len"}, 32'(prog_len), 32'(m_len));
    checkOutput({tag, "_field_err"}, 32'(field_err), 32'(ferr));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(ovf));
    checkOutput({tag, "_err_index"}, 32'(err_index), 32'(eidx));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Compare process: every cycle, the write port and done against the model.
  always @(negedge clk) begin : compare
    bit exp_wr;
    if (chk_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests_run++; tests_failed++;
        $display("[TB] FAIL write_missed: addr %0d data 0x%0h due cycle %0d, now %0d",
                 exp_q[0].addr, exp_q[0].data, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      exp_wr = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      tests_run++;
      if (prog_wr_en !== exp_wr ||
          (exp_wr && (prog_wr_addr !== exp_q[0].addr || prog_wr_data !== exp_q[0].data))) begin
        tests_failed++;
        if (exp_wr)
          $display("[TB] FAIL write cyc %0d: got en=%b addr=%0d data=0x%0h, expected en=1 addr=%0d data=0x%0h",
                   cyc, prog_wr_en, prog_wr_addr, prog_wr_data, exp_q[0].addr, exp_q[0].data);
        else
          $display("[TB] FAIL write cyc %0d: got en=%b addr=%0d data=0x%0h, expected en=0",
                   cyc, prog_wr_en, prog_wr_addr, prog_wr_data);
      end
      if (exp_wr) void'(exp_q.pop_front());
      tests_run++;
      if (done !== (cyc == exp_done_cyc)) begin
        tests_failed++;
        $display("[TB] FAIL done cyc %0d: got %b, expected %b", cyc, done, (cyc == exp_done_cyc));
      end
    end
  end

  initial begin : stimulus
    desc_t       madd, dly, lut_bad, d;
    logic [31:0] w;
    bit          ok;

    reset = 1'b1; load_start = 1'b0; load_end = 1'b0; in_valid = 1'b0;
    in_op = '0; in_src_a = '0; in_src_b = '0; in_src_c = '0;
    in_src_a_reg = 1'b0; in_src_b_reg = 1'b0; in_src_c_reg = 1'b0;
    in_dest = '0; in_shift = '0; in_sat_dis = 1'b0; in_shift_dis = 1'b0; in_res_addr = '0;
    m_ptr = 0; m_acc = 0; m_eidx = 0; m_len = 0; m_ferr = 0; m_ovf = 0; m_loading = 0;

    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    checkOutput("rst_wr_en", 32'(prog_wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(prog_wr_addr), 32'd0);
    checkOutput("rst_wr_data", prog_wr_data, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_prog_len", 32'(prog_len), 32'd0);
    checkOutput("rst_flags", 32'({field_err, overflow}), 32'd0);
    checkOutput("rst_err_index", 32'(err_index), 32'd0);
    reset = 1'b0;

    // Hand-computed words pin the model itself.
    madd    = mk_alu(BLOCK_INSTR_MADD, 1, 2, 3, 4, 5);
    dly     = mk_res(BLOCK_INSTR_DELAY_READ, 6, 12'h8A5);
    lut_bad = mk_res(BLOCK_INSTR_LUT_READ, 3, 12'h010);
    lut_bad.shift = 5'd2;
    model_word(madd, w, ok);
    checkOutput("pin_madd_word", w, 32'h0A83_1044);
    checkOutput("pin_madd_legal", 32'(ok), 32'd1);
    model_word(dly, w, ok);
    checkOutput("pin_delay_word", w, 32'h8A56_0030);
    checkOutput("pin_delay_legal", 32'(ok), 32'd1);
    model_word(lut_bad, w, ok);
    checkOutput("pin_lut_shift_illegal", 32'(ok), 32'd0);

    // Three MADDs, then padding of addresses 3..7.
    applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 1, madd);
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(0, 0, 1, madd);
    applyStimulus(0, 0, 1, madd);
    applyStimulus(0, 1, 0, '0);
    idle(12);
    check_end("madd3", 3, 0, 0, 0);

    // Single resource-format word at address 0.
    applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 1, dly);
    applyStimulus(0, 1, 0, '0);
    idle(12);
    check_end("delay", 1, 0, 0, 0);

    // Illegal second descriptor is skipped; the next legal one takes addr 1.
    applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 1, madd);
    applyStimulus(0, 0, 1, lut_bad);
    applyStimulus(0, 0, 1, dly);
    applyStimulus(0, 1, 0, '0);
    idle(12);
    check_end("illegal", 2, 1, 0, 1);

    // Ten back-to-back descriptors into eight words: overflow, no padding.
    applyStimulus(1, 0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) d = mk_res(BLOCK_INSTR_MEM_WRITE, i, 12'(12'h1A3 * i));
      else begin
        d = mk_alu((i % 2) ? BLOCK_INSTR_ADD : BLOCK_INSTR_SHL, i, 15 - i, i / 2, i, i * 3);
        d.src_a_reg = i[0]; d.sat_dis = i[1]; d.shift_dis = i[2]; d.src_c_reg = i[0];
      end
      applyStimulus(0, 0, 1, d);
    end
    applyStimulus(0, 1, 0, '0);
    idle(6);
    check_end("overflow", 8, 0, 1, 8);

    // Restart mid-load clears flags and drops the coincident descriptor.
    applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 1, lut_bad);
    applyStimulus(0, 0, 1, madd);
    applyStimulus(0, 0, 1, madd);
    applyStimulus(1, 1, 1, madd);
    applyStimulus(0, 0, 1, dly);
    checkOutput("restart_field_err", 32'(field_err), 32'd0);
    checkOutput("restart_err_index", 32'(err_index), 32'd0);
    checkOutput("restart_in_ready", 32'(in_ready), 32'd1);
    checkOutput("restart_wr_dropped", 32'(prog_wr_en), 32'd0);
    applyStimulus(0, 1, 0, '0);
    idle(12);
    check_end("restart", 1, 0, 0, 0);

    // Reset in the middle of padding stops all writes at once.
    applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 1, madd);
    applyStimulus(0, 0, 1, dly);
    applyStimulus(0, 1, 0, '0);
    idle(2);
    applyReset();
    checkOutput("pad_rst_wr_en", 32'(prog_wr_en), 32'd0);
    checkOutput("pad_rst_busy", 32'(busy), 32'd0);
    checkOutput("pad_rst_prog_len", 32'(prog_len), 32'd0);
    checkOutput("pad_rst_wr_addr", 32'(prog_wr_addr), 32'd0);
    checkOutput("pad_rst_wr_data", prog_wr_data, 32'd0);
    reset = 1'b0;
    idle(12);
    checkOutput("pad_rst_no_writes", 32'(exp_q.size()), 32'd0);

    // Descriptor accepted together with load_end, then padding.
    applyStimulus(1, 0, 0, '0);
    applyStimulus(0, 0, 1, dly);
    applyStimulus(0, 1, 1, madd);
    idle(12);
    check_end("end_with_desc", 2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
